// File: rtl/donut_pkg.sv
// Shared geometry defaults, FSM state encoding and the tagged-pixel record
// for the donut frame reader.
package donut_pkg;

    localparam int H_ACTIVE_DEF = 400;
    localparam int V_ACTIVE_DEF = 176;
    localparam int PIX_W        = 4;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int FIFO_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_t;

endpackage

// File: rtl/donut_pix_fifo.sv
// Two-entry pixel FIFO with a registered head; push and pop may coincide,
// flush empties it in one cycle.
module donut_pix_fifo
    import donut_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  pix_t       din_i,
    input  logic       pop_i,
    output pix_t       dout_o,
    output logic [1:0] count_o
);

    pix_t       head_q, tail_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din_i;
                    else               tail_q <= din_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= din_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o  = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/donut_frame_reader.sv
// Streams one frame of 4-bit pixels out of a synchronous ROM with x/y and
// frame markers, credit-limited so FIFO plus in-flight reads never exceed 2.
module donut_frame_reader
    import donut_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_DEF,
    parameter int          V_ACTIVE  = V_ACTIVE_DEF,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        loop_i,
    input  logic        abort_i,
    output logic        rom_cen_o,
    output logic [31:0] rom_addr_o,
    input  logic [3:0]  rom_data_i,
    output logic        pix_valid_o,
    output logic [3:0]  pix_data_o,
    output logic [8:0]  pix_x_o,
    output logic [7:0]  pix_y_o,
    output logic        pix_sof_o,
    output logic        pix_eol_o,
    output logic        pix_eof_o,
    input  logic        pix_ready_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    state_e         state_q, state_d;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [31:0]    addr_q;
    logic           infl_q;
    logic [X_W-1:0] tag_x_q;
    logic [Y_W-1:0] tag_y_q;
    logic           tag_sof_q, tag_eol_q, tag_eof_q;

    pix_t       rx_pix, fifo_head, pix;
    logic [1:0] fifo_cnt;
    logic [2:0] occ_after;
    logic       bypass, pop, fifo_pop, fifo_push, issue, last_x, last_px;

    assign last_x  = (x_q == X_W'(H_ACTIVE - 1));
    assign last_px = last_x && (y_q == Y_W'(V_ACTIVE - 1));

    always_comb begin
        rx_pix      = '0;
        rx_pix.data = rom_data_i;
        rx_pix.x    = tag_x_q;
        rx_pix.y    = tag_y_q;
        rx_pix.sof  = tag_sof_q;
        rx_pix.eol  = tag_eol_q;
        rx_pix.eof  = tag_eof_q;
    end

    // An arriving read bypasses an empty FIFO so pixel (0,0) shows the cycle
    // its data lands; it is parked in the FIFO only if not taken right away.
    assign bypass      = infl_q && (fifo_cnt == 2'd0);
    assign pix         = bypass ? rx_pix : fifo_head;
    assign pix_valid_o = infl_q || (fifo_cnt != 2'd0);
    assign pop         = pix_valid_o && pix_ready_i;
    assign fifo_pop    = pop && !bypass;
    assign fifo_push   = infl_q && !(bypass && pix_ready_i);

    assign occ_after = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && !abort_i && (occ_after < 3'(FIFO_DEPTH));

    assign rom_cen_o    = issue;
    assign rom_addr_o   = addr_q;
    assign pix_data_o   = pix.data;
    assign pix_x_o      = pix.x;
    assign pix_y_o      = pix.y;
    assign pix_sof_o    = pix.sof;
    assign pix_eol_o    = pix.eol;
    assign pix_eof_o    = pix.eof;
    assign frame_done_o = pop && pix.eof && !abort_i;
    assign busy_o       = (state_q != IDLE);

    donut_pix_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (abort_i),
        .push_i  (fifo_push),
        .din_i   (rx_pix),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (issue && last_px && !loop_i) state_d = DRAIN;
            DRAIN:   if (frame_done_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Raster counters run alongside a linear address so no multiply is needed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= BASE_ADDR;
            infl_q    <= 1'b0;
            tag_x_q   <= '0;
            tag_y_q   <= '0;
            tag_sof_q <= 1'b0;
            tag_eol_q <= 1'b0;
            tag_eof_q <= 1'b0;
        end else if (abort_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= BASE_ADDR;
            infl_q <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                tag_x_q   <= x_q;
                tag_y_q   <= y_q;
                tag_sof_q <= (x_q == '0) && (y_q == '0);
                tag_eol_q <= last_x;
                tag_eof_q <= last_px;
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_px ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
                addr_q <= last_px ? BASE_ADDR : addr_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_donut_frame_reader.sv
// Directed bench for donut_frame_reader on a reduced 8x4 frame with a
// synchronous ROM model and an in-order pixel model.
module tb_donut_frame_reader;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          FR   = H * V;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0, loop_i = 1'b0, abort_i = 1'b0, pix_ready_i = 1'b0;
    logic        rom_cen_o;
    logic [31:0] rom_addr_o;
    logic [3:0]  rom_data_i;
    logic        pix_valid_o, pix_sof_o, pix_eol_o, pix_eof_o, busy_o, frame_done_o;
    logic [3:0]  pix_data_o;
    logic [8:0]  pix_x_o;
    logic [7:0]  pix_y_o;

    int n_cmp = 0;
    int n_err = 0;

    donut_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_i(loop_i), .abort_i(abort_i),
        .rom_cen_o(rom_cen_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
        .pix_sof_o(pix_sof_o), .pix_eol_o(pix_eol_o), .pix_eof_o(pix_eof_o),
        .pix_ready_i(pix_ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] rom_f(logic [31:0] a);
        logic [31:0] t;
        t = a ^ (a >> 3);
        return t[3:0];
    endfunction

    always @(posedge clk_i) if (rom_cen_o) rom_data_i <= rom_f(rom_addr_o);

    function automatic logic [25:0] pk(logic v, logic [3:0] d, logic [8:0] x, logic [7:0] y,
                                       logic s, logic l, logic e, logic dn);
        return {v, d, x, y, s, l, e, dn};
    endfunction

    function automatic logic [25:0] exp_px(int q, logic rdy);
        int x, y;
        x = q % H;
        y = q / H;
        return pk(1'b1, rom_f(BASE + 32'(q)), x[8:0], y[7:0], q == 0, x == H - 1,
                  q == FR - 1, rdy && (q == FR - 1));
    endfunction

    function automatic logic [25:0] obs_px();
        return pk(pix_valid_o, pix_data_o, pix_x_o, pix_y_o, pix_sof_o, pix_eol_o,
                  pix_eof_o, frame_done_o);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // Start in cycle 0, then stream nfr frames; loop_i stays high until the
    // last frame's final address. mid>0 pulses start_i again in that cycle.
    task automatic run_frames(input int nfr, input bit rnd, input int mid);
        int c, n_iss, n_acc, n_done, first_pix, q, lim;
        int done_c[2];
        c = 0; n_iss = 0; n_acc = 0; n_done = 0; first_pix = -1;
        done_c[0] = -1; done_c[1] = -1;
        lim = nfr * FR * 8 + 50;
        cyc();
        start_i = 1'b1; pix_ready_i = 1'b1; loop_i = (nfr > 1);
        smp();
        chk("idle_cen", rom_cen_o, 0);
        chk("idle_busy", busy_o, 0);
        while (n_acc < nfr * FR && c < lim) begin
            cyc();
            c++;
            start_i = (c == mid);
            pix_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            loop_i = (n_iss < (nfr - 1) * FR);
            smp();
            chk("outstanding", (n_iss - n_acc) <= 2, 1);
            if (rom_cen_o) begin
                chk("addr", rom_addr_o, BASE + 32'(n_iss % FR));
                if (n_iss == 0) chk("t_first_cen", c, 1);
                n_iss++;
            end
            if (pix_valid_o) begin
                q = n_acc % FR;
                chk("pix", obs_px(), exp_px(q, pix_ready_i));
                if (first_pix < 0) first_pix = c;
                if (pix_ready_i) begin
                    if (q == FR - 1) begin
                        if (n_done < 2) done_c[n_done] = c;
                        n_done++;
                    end
                    n_acc++;
                end
            end else begin
                chk("done_idle", frame_done_o, 0);
            end
        end
        chk("pix_count", n_acc, nfr * FR);
        chk("t_first_pix", first_pix, 2);
        chk("n_done", n_done, nfr);
        if (!rnd) begin
            chk("t_done0", done_c[0], FR + 1);
            if (nfr > 1) chk("t_done_gap", done_c[1] - done_c[0], FR);
        end
        start_i = 1'b0;
        loop_i = 1'b0;
        cyc();
        smp();
        chk("busy_end", busy_o, 0);
        chk("valid_end", pix_valid_o, 0);
    endtask

    // Stream with ready=1, then abort in cycle n with the given ready level.
    task automatic abort_at(input int n, input bit rdy);
        cyc();
        start_i = 1'b1; pix_ready_i = 1'b1;
        smp();
        for (int i = 1; i < n; i++) begin
            cyc();
            start_i = 1'b0;
            smp();
        end
        cyc();
        start_i = 1'b0; pix_ready_i = rdy; abort_i = 1'b1;
        smp();
        chk("abort_no_done", frame_done_o, 0);
        chk("abort_no_cen", rom_cen_o, 0);
        cyc();
        abort_i = 1'b0; pix_ready_i = 1'b1;
        smp();
        chk("abort_valid", pix_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_addr", rom_addr_o, BASE);
        cyc();
        smp();
        chk("abort_idle", {rom_cen_o, pix_valid_o, busy_o}, 0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        chk("reset", {rom_cen_o, busy_o, rom_addr_o, obs_px()}, {2'b00, BASE, 26'd0});
        cyc();
        rst_ni = 1'b1;
        cyc();
        smp();
        chk("post_reset_idle", {rom_cen_o, busy_o, pix_valid_o}, 0);

        run_frames(1, 1'b0, FR / 2);
        run_frames(2, 1'b1, 0);
        run_frames(1, 1'b1, 0);
        run_frames(2, 1'b0, 0);

        abort_at(12, 1'b0);
        run_frames(1, 1'b0, 0);
        abort_at(FR + 1, 1'b1);
        run_frames(1, 1'b0, 0);

        cyc();
        start_i = 1'b1; pix_ready_i = 1'b1;
        smp();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            start_i = 1'b0;
            smp();
        end
        cyc();
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async", {rom_cen_o, busy_o, rom_addr_o, obs_px()}, {2'b00, BASE, 26'd0});
        cyc();
        cyc();
        rst_ni = 1'b1;
        smp();
        chk("rst_release_idle", {rom_cen_o, busy_o, pix_valid_o}, 0);
        cyc();
        smp();
        chk("rst_still_idle", {rom_cen_o, busy_o, pix_valid_o}, 0);
        run_frames(1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/donut_frame_reader.md
DONUT_FRAME_READER -- requirements
Module: donut_frame_reader

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 400, meaning pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 176, meaning lines per frame (frame = 70400 pixels).
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning ROM address of pixel (0,0).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start_i, input, 1 bit: single-cycle frame start request.
REQ-007 The block SHALL have port loop_i, input, 1 bit: when high, restart the frame seamlessly after the last pixel.
REQ-008 The block SHALL have port abort_i, input, 1 bit: synchronous abort and flush.
REQ-009 The block SHALL have port rom_cen_o, output, 1 bit: ROM read clock enable.
REQ-010 The block SHALL have port rom_addr_o, output, 32 bits: ROM read address.
REQ-011 The block SHALL have port rom_data_i, input, 4 bits: ROM read data, valid one cycle after rom_cen_o.
REQ-012 The block SHALL have pixel stream outputs pix_valid_o (1), pix_data_o (4), pix_x_o (9), pix_y_o (8), pix_sof_o (1), pix_eol_o (1) and pix_eof_o (1), plus input pix_ready_i (1).
REQ-013 The block SHALL have status outputs busy_o (1) and frame_done_o (1; one-cycle pulse).

Function
REQ-014 The FSM SHALL have states IDLE, RUN (issuing reads) and DRAIN (all reads issued, FIFO emptying).
REQ-015 IDLE -> RUN on start_i; RUN -> DRAIN when the last frame address is issued with loop_i low; DRAIN -> IDLE when the EOF pixel is accepted.
REQ-016 start_i SHALL be ignored outside IDLE.
REQ-017 Addresses SHALL be generated by an incrementing counter (no multiplier): BASE_ADDR + y*H_ACTIVE + x, with x wrapping at H_ACTIVE-1 and y at V_ACTIVE-1.
REQ-018 rom_cen_o SHALL be asserted only if FIFO occupancy + reads in flight - pops this cycle < 2, the FIFO depth.
REQ-019 rom_data_i SHALL be captured into the FIFO exactly one cycle after its rom_cen_o cycle, tagged with x, y, sof (0,0), eol (x=H_ACTIVE-1) and eof (last pixel).
REQ-020 Latency: start_i high in cycle 0 -> rom_cen_o high with BASE_ADDR in cycle 1 -> pix_valid_o high with pixel (0,0) in cycle 2.
REQ-021 With pix_ready_i held high, the block SHALL output one pixel per cycle with no bubbles, including across loop wrap.
REQ-022 While pix_valid_o=1 and pix_ready_i=0, all pix_* outputs SHALL remain stable; no data SHALL be lost or duplicated.
REQ-023 Loop: if loop_i is high in the cycle the last address is issued, the next issue SHALL be BASE_ADDR with no idle cycle, and the FSM SHALL stay in RUN.
REQ-024 frame_done_o SHALL pulse in the cycle the eof pixel is accepted (pix_valid_o & pix_ready_i).
REQ-025 abort_i SHALL take priority over all other inputs: next cycle in IDLE, FIFO empty, in-flight read discarded, pix_valid_o=0, counters at 0, no frame_done_o.
REQ-026 busy_o SHALL be high in RUN and DRAIN, and low in IDLE.

Reset
REQ-027 On rst_ni low, asynchronously: FSM=IDLE, FIFO empty, in-flight flag=0, x=y=0, rom_cen_o=0, rom_addr_o=BASE_ADDR, and all pix_* outputs, busy_o and frame_done_o = 0.
REQ-028 Reset deassertion mid-frame SHALL leave the block in IDLE; the next frame SHALL start from (0,0) only on a new start_i.

Structure
REQ-029 The package donut_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, PIX_W=4, FRAME_PIXELS=70400, the FSM state enum and the pixel-tag struct (data, x, y, sof, eol, eof).
REQ-030 The 2-entry FIFO SHALL be the sub-module donut_pix_fifo (registered output, push/pop in the same cycle allowed, abort flush).

Verification
REQ-031 The bench SHALL cover reset and start with ready=1: start in cycle 0 -> addr 0 in cycle 1, pixel (0,0) with sof in cycle 2, 70400 consecutive pixels, eof+frame_done in cycle 70401, busy low in cycle 70402.
REQ-032 The bench SHALL cover random backpressure (50% ready): pixel sequence matches the ROM model 1:1, outputs stable while stalled, at most 2 outstanding (FIFO + in-flight).
REQ-033 The bench SHALL cover loop_i=1 for 2 frames: addr 70399 followed directly by addr 0, exactly 2 frame_done pulses 70400 cycles apart.
REQ-034 The bench SHALL cover abort_i at pixel 1000 with ready=0: next cycle valid=0, busy=0; a new start restarts at (0,0) with no stale data.
REQ-035 The bench SHALL cover start_i pulsed mid-frame: no effect; eol asserted at x=399 on every line and y increments to 175.
REQ-036 The bench SHALL cover rst_ni asserted mid-frame: all outputs zero immediately (asynchronously), IDLE after release.
